// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg
// Shared definitions for the pulse_sync crossing and its source-side feeder.
//   - FSM state encoding of pulse_sync_feeder (state_t / ST_*)
//   - ACK_TO_DEF: default number of cycles to wait for busy after an issue
package pulse_sync_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ISSUE     = 2'd1;
  localparam state_t ST_WAIT_BUSY = 2'd2;
  localparam state_t ST_WAIT_DONE = 2'd3;

  localparam int ACK_TO_DEF = 16;

endpackage

// File: rtl/pulse_sync_feeder_cnt.sv
// sat_up_down_cnt
// Width-parameterized saturating up/down counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one (held at all-ones, ovf_stb raised instead)
//   dec        : count down by one (held at zero)
//   cnt        : current count
//   ovf_stb    : combinational strobe, high in a cycle where an increment is
//                dropped because the counter is saturated
// inc and dec together leave the count unchanged and never overflow.
module sat_up_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf_stb
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    ovf_stb = 1'b0;
    if (inc && !dec) begin
      if (cnt == MAX) ovf_stb = 1'b1;
      else            cnt_nxt = cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/pulse_sync_feeder.sv
// pulse_sync_feeder
// Source-side driver for the pulse_sync crossing, entirely in clk_a.
// Event strobes are counted in a saturating pending counter and issued one
// at a time as single-cycle sig_a pulses, paced by the busy handshake.
//   clk_a     : clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   ev_in     : event strobe, one event per high cycle
//   busy      : from pulse_sync, high while a crossing is in flight
//   clr_err   : synchronous clear of ovf / to_err (a same-cycle set wins)
//   sig_a     : registered single-cycle issue pulse to pulse_sync
//   pending   : events accepted but not yet issued
//   idle      : FSM in IDLE and nothing pending
//   ovf       : sticky, an event was dropped at saturation
//   to_err    : sticky, busy did not rise within ACK_TO cycles of an issue
//   dbg_state : current FSM state (ST_* encoding from pulse_sync_pkg)
//
// Handshake: an issue (sig_a high for one cycle) is only started while busy
// is low; busy must then rise within ACK_TO cycles and the next issue waits
// until busy has fallen again, so pulse_sync never sees a pulse during its
// dead time. A missing busy response is abandoned and the event is treated
// as consumed.
module pulse_sync_feeder
  import pulse_sync_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic             clk_a,
  input  logic             rst_n,
  input  logic             ev_in,
  input  logic             busy,
  input  logic             clr_err,
  output logic             sig_a,
  output logic [CNT_W-1:0] pending,
  output logic             idle,
  output logic             ovf,
  output logic             to_err,
  output logic [1:0]       dbg_state
);

  localparam int TO_W = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            issue_dec;
  logic            to_set;
  logic            ovf_stb;

  sat_up_down_cnt #(.W(CNT_W)) u_pending (
    .clk     (clk_a),
    .rst_n   (rst_n),
    .inc     (ev_in),
    .dec     (issue_dec),
    .cnt     (pending),
    .ovf_stb (ovf_stb)
  );

  always_comb begin
    state_nxt = state;
    issue_dec = 1'b0;
    to_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pending != '0) && !busy) begin
          state_nxt = ST_ISSUE;
          issue_dec = 1'b1;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = ST_IDLE;
          to_set    = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sig_a <= 1'b0;
    end else begin
      state <= state_nxt;
      // Flopped copy of "next state is ISSUE" so sig_a is a clean register
      // output that tracks the ISSUE state exactly.
      sig_a <= (state_nxt == ST_ISSUE);
    end
  end

  // Timeout counter: cleared while issuing so it starts at 0 on entry to
  // WAIT_BUSY, then counts each WAIT_BUSY cycle up to TO_LAST.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      to_cnt <= '0;
    end else if ((state == ST_WAIT_BUSY) && (to_cnt != TO_LAST)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      ovf    <= 1'b0;
      to_err <= 1'b0;
    end else begin
      if (ovf_stb)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (to_set)       to_err <= 1'b1;
      else if (clr_err) to_err <= 1'b0;
    end
  end

  assign idle      = (state == ST_IDLE) && (pending == '0);
  assign dbg_state = state;

endmodule
